// File: rtl/mixer_pkg.sv
// mixer_pkg: shared constants, FSM state type and sine-table contents for
// poly_voice_mixer.
//   PHASE_W    phase accumulator width: {quad[1:0], addr[9:0], frac[9:0]}
//   ROM_ADDR_W quarter-wave table address width
//   SAMPLE_W   signed sample width (table output and mixer output)
package mixer_pkg;

  localparam int PHASE_W    = 22;
  localparam int ROM_ADDR_W = 10;
  localparam int SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } mixer_state_e;

  // Quarter-wave table entry. The table is the parabola a*(2048-a)/32, which
  // tracks sin(pi/2 * a/1024) closely, is never negative and peaks at exactly
  // 32767 for a = 1023. It is a pure function of the address, so synthesis
  // folds it into a 1024 x 16 constant table.
  function automatic logic [SAMPLE_W-1:0] rom_value(input logic [ROM_ADDR_W-1:0] addr);
    logic [21:0] prod;
    prod = {12'd0, addr} * (22'd2048 - {12'd0, addr});
    return SAMPLE_W'(prod >> 5);
  endfunction

endpackage

// File: rtl/voice_sine_lookup.sv
// voice_sine_lookup: full-wave sine from a quarter-wave table, one-cycle
// registered result.
//   clk_i, reset_i  clock, asynchronous active-high reset (output clears to 0)
//   phase_i         22-bit phase {quad, addr, frac}; frac is not used
//   sine_o          signed sample for the phase presented on the previous cycle
// Quadrant handling: odd quadrants read the table mirrored (~addr), the upper
// two quadrants negate the result.
module voice_sine_lookup
  import mixer_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [PHASE_W-1:0]         phase_i,
  output logic signed [SAMPLE_W-1:0] sine_o
);

  logic [1:0]                 quad;
  logic [ROM_ADDR_W-1:0]      addr;
  logic [ROM_ADDR_W-1:0]      rom_addr;
  logic [SAMPLE_W-1:0]        mag;
  logic signed [SAMPLE_W-1:0] sine_d;
  logic signed [SAMPLE_W-1:0] sine_q;
  logic                       unused_frac;

  assign quad        = phase_i[21:20];
  assign addr        = phase_i[19:10];
  assign unused_frac = ^phase_i[9:0];
  assign rom_addr    = quad[0] ? ~addr : addr;
  assign mag         = rom_value(rom_addr);
  // mag never exceeds 32767, so negation cannot overflow.
  assign sine_d      = quad[1] ? -$signed(mag) : $signed(mag);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sine_q <= '0;
    else         sine_q <= sine_d;
  end

  assign sine_o = sine_q;

endmodule

// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: N-voice additive synth core. One time-shared sine lookup
// serves NUM_VOICES phase accumulators; each voice is scaled by its gain and
// summed, then the sum is scaled down to a 16-bit sample.
//   clk, reset     clock, asynchronous active-high reset
//   generate_next  sample-rate strobe; starts a frame when idle
//   step_size      per-voice phase step, voice v at [v*STEP_W +: STEP_W]
//   gain           per-voice unsigned gain Q0.GAIN_W, voice v at [v*GAIN_W +: GAIN_W]
//   enable         voice sounds and advances
//   note_on        voice phase cleared at the start of its slot
//   sample         signed mixed sample, held between frames
//   sample_ready   one-cycle pulse when sample updates
//   busy           frame in progress
//   overrun        sticky: generate_next seen while busy (cleared by reset only)
//   dbg_state      current FSM state
// Build option: MIXER_SATURATE_EN clamps the scaled sum to the 16-bit range;
// without it the low 16 bits are taken (two's-complement wrap).
//
// Strobe protocol: generate_next is a one-cycle request accepted only in IDLE
// (inputs are snapshotted on that edge); a request while busy, including the
// DONE cycle, is dropped and flags overrun. sample_ready pulses for exactly
// one cycle, 2*NUM_VOICES+2 cycles after the accepted request, and sample
// holds its value until the next pulse.
module poly_voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int STEP_W     = 20,
  parameter int GAIN_W     = 8,
  parameter int OUT_SHIFT  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         generate_next,
  input  logic [NUM_VOICES*STEP_W-1:0] step_size,
  input  logic [NUM_VOICES*GAIN_W-1:0] gain,
  input  logic [NUM_VOICES-1:0]        enable,
  input  logic [NUM_VOICES-1:0]        note_on,
  output logic signed [SAMPLE_W-1:0]   sample,
  output logic                         sample_ready,
  output logic                         busy,
  output logic                         overrun,
  output mixer_state_e                 dbg_state
);

  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W  = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W   = PROD_W + $clog2(NUM_VOICES);
  localparam int SHIFT   = GAIN_W + OUT_SHIFT;
  localparam logic [VOICE_W-1:0] LAST_V = VOICE_W'(NUM_VOICES - 1);

  mixer_state_e                   state_q, state_d;
  logic [VOICE_W-1:0]             v_q, v_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]     sample_q, sample_d;
  logic                           ready_q, ready_d;
  logic                           overrun_q, overrun_d;
  logic                           snap_load;

  logic [NUM_VOICES*STEP_W-1:0]   step_s_q;
  logic [NUM_VOICES*GAIN_W-1:0]   gain_s_q;
  logic [NUM_VOICES-1:0]          en_s_q;
  logic [NUM_VOICES-1:0]          non_s_q;

  logic [PHASE_W-1:0]             phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]             phase_eff;
  logic [PHASE_W-1:0]             phase_next;
  logic [STEP_W-1:0]              cur_step;
  logic [GAIN_W-1:0]              cur_gain;
  logic signed [SAMPLE_W-1:0]     sine;
  logic signed [PROD_W-1:0]       prod;
  logic signed [SAMPLE_W-1:0]     s_out;

  // Current voice's snapshot fields; a pending note-on clears the phase
  // before it is used as the lookup address.
  assign cur_step   = step_s_q[v_q*STEP_W +: STEP_W];
  assign cur_gain   = gain_s_q[v_q*GAIN_W +: GAIN_W];
  assign phase_eff  = non_s_q[v_q] ? '0 : phase_q[v_q];
  assign phase_next = phase_eff + PHASE_W'(cur_step);

  voice_sine_lookup u_lookup (
    .clk_i   (clk),
    .reset_i (reset),
    .phase_i (phase_eff),
    .sine_o  (sine)
  );

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod = PROD_W'(sine) * PROD_W'($signed({1'b0, cur_gain}));

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-32768);
  logic signed [ACC_W-1:0] s_full;
  assign s_full = acc_q >>> SHIFT;
  always_comb begin
    s_out = SAMPLE_W'(s_full);
    if (s_full > S_MAX)      s_out = 16'sh7FFF;
    else if (s_full < S_MIN) s_out = 16'sh8000;
  end
`else
  assign s_out = SAMPLE_W'(acc_q >>> SHIFT);
`endif

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    ready_d   = 1'b0;
    snap_load = 1'b0;
    overrun_d = overrun_q | (generate_next & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (generate_next) begin
          state_d   = FETCH;
          v_d       = '0;
          acc_d     = '0;
          snap_load = 1'b1;
        end
      end
      FETCH: state_d = ACC;
      ACC: begin
        // Lookup issued in FETCH is valid now.
        if (en_s_q[v_q]) acc_d = acc_q + ACC_W'(prod);
        if (v_q == LAST_V) begin
          state_d = DONE;
        end else begin
          v_d     = v_q + VOICE_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        sample_d = s_out;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      v_q       <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_s_q <= '0;
      gain_s_q <= '0;
      en_s_q   <= '0;
      non_s_q  <= '0;
    end else if (snap_load) begin
      step_s_q <= step_size;
      gain_s_q <= gain;
      en_s_q   <= enable;
      non_s_q  <= note_on;
    end
  end

  // The phase update lands on the edge that also captures the lookup, so the
  // lookup always sees the pre-increment (possibly cleared) phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else if (state_q == FETCH) begin
      phase_q[v_q] <= en_s_q[v_q] ? phase_next : phase_eff;
    end
  end

  assign sample       = sample_q;
  assign sample_ready = ready_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule
